// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: opcode set, control width,
// FSM state encoding and latency-class selector.
package alu_sequencer_pkg;

  localparam int OPC_W  = 4;
  localparam int CTL_W  = 13;
  localparam int DATA_W = 32;
  localparam int RES_W  = 64;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_SHR  = 4'd4,
    OP_SHRA = 4'd5,
    OP_SHL  = 4'd6,
    OP_ROR  = 4'd7,
    OP_ROL  = 4'd8,
    OP_AND  = 4'd9,
    OP_OR   = 4'd10,
    OP_NEG  = 4'd11,
    OP_NOT  = 4'd12
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Which latency the EXEC counter is loaded with
  typedef enum logic [1:0] {
    LAT_ONE = 2'd0,
    LAT_MUL = 2'd1,
    LAT_DIV = 2'd2
  } lat_sel_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response and ALU-side signals of the sequencer.
// master = requester that also models the ALU; slave = the sequencer.
interface alu_sequencer_if;
  import alu_sequencer_pkg::*;

  logic              start;
  logic [OPC_W-1:0]  opcode;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic              ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [CTL_W-1:0]  alu_ctl;
  logic [RES_W-1:0]  alu_out;
  logic [RES_W-1:0]  z_out;
  logic              done;
  logic              err;

  modport master (
    output start, opcode, a_in, b_in, alu_out,
    input  ready, op_a, op_b, alu_ctl, z_out, done, err
  );

  modport slave (
    input  start, opcode, a_in, b_in, alu_out,
    output ready, op_a, op_b, alu_ctl, z_out, done, err
  );

endinterface

// File: rtl/alu_sequencer_decode.sv
// Combinational opcode decoder: one-hot ALU control, latency class and
// illegal-opcode flag.
module alu_op_decode
  import alu_sequencer_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output logic [CTL_W-1:0] ctl,
  output lat_sel_e         lat_sel,
  output logic             illegal
);

  // Decode opcode; codes beyond the last legal one produce no control bit
  always_comb begin
    ctl     = '0;
    lat_sel = LAT_ONE;
    illegal = 1'b0;
    if (opcode > OP_NOT) begin
      illegal = 1'b1;
    end else begin
      ctl = CTL_W'(1) << opcode;
    end
    case (opcode)
      OP_MUL:  lat_sel = LAT_MUL;
      OP_DIV:  lat_sel = LAT_DIV;
      default: lat_sel = LAT_ONE;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU sequencer: accepts one operation in IDLE, holds the
// one-hot ALU control for the operation's latency, captures the result
// and pulses done. Illegal opcodes and divide-by-zero skip straight to DONE
// with err set and the result register untouched.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic        clock,
  input  logic        clear,
  alu_sequencer_if.slave bus
);

  localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  state_e            state, state_nx;
  logic [OPC_W-1:0]  op_q;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] op_a_q, op_b_q;
  logic [RES_W-1:0]  z_q;
  logic              err_q;

  logic [OPC_W-1:0]  dec_opc;
  logic [CTL_W-1:0]  dec_ctl;
  lat_sel_e          dec_lat;
  logic              dec_illegal;
  logic              accept;
  logic              reject;
  logic [CNT_W-1:0]  lat_load;

  // In IDLE the decoder looks at the incoming request; otherwise it drives
  // the control for the operation already latched.
  assign dec_opc = (state == ST_IDLE) ? bus.opcode : op_q;

  alu_op_decode u_dec (
    .opcode  (dec_opc),
    .ctl     (dec_ctl),
    .lat_sel (dec_lat),
    .illegal (dec_illegal)
  );

  assign accept = bus.start && (state == ST_IDLE);
  assign reject = dec_illegal || ((bus.opcode == OP_DIV) && (bus.b_in == '0));

  // Map latency class to the counter preload
  always_comb begin
    lat_load = CNT_W'(1);
    case (dec_lat)
      LAT_MUL: lat_load = CNT_W'(MUL_LAT);
      LAT_DIV: lat_load = CNT_W'(DIV_LAT);
      default: lat_load = CNT_W'(1);
    endcase
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (clear) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // FSM next-state
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = reject ? ST_DONE : ST_EXEC;
      ST_EXEC: if (cnt == CNT_W'(1)) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Operand/opcode latch, latency counter, result capture and error flag
  always_ff @(posedge clock) begin
    if (clear) begin
      op_q   <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      cnt    <= '0;
      z_q    <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q   <= bus.opcode;
            op_a_q <= bus.a_in;
            op_b_q <= bus.b_in;
            err_q  <= reject;
            cnt    <= reject ? '0 : lat_load;
          end
        end
        ST_EXEC: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) z_q <= bus.alu_out;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready   = (state == ST_IDLE);
  assign bus.done    = (state == ST_DONE);
  assign bus.alu_ctl = (state == ST_EXEC) ? dec_ctl : '0;
  assign bus.op_a    = op_a_q;
  assign bus.op_b    = op_b_q;
  assign bus.z_out   = z_q;
  assign bus.err     = err_q;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter MUL_LAT, default 4, EXEC cycles held for MUL (min 1).
REQ-002 SHALL have parameter DIV_LAT, default 32, EXEC cycles held for DIV (min 1).
REQ-003 SHALL have port clock  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port clear  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request; accepted only when start && ready.
REQ-006 SHALL have port opcode  input  4  0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 SHR, 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 AND, 10 OR, 11 NEG, 12 NOT, 13-15 illegal.
REQ-007 SHALL have ports a_in, b_in  input  32 each  operands, sampled on accept.
REQ-008 SHALL have port ready  output  1  high only in IDLE.
REQ-009 SHALL have ports op_a, op_b  output  32 each  latched operands driven to the ALU.
REQ-010 SHALL have port alu_ctl  output  13  one-hot ALU control, bit n = opcode n.
REQ-011 SHALL have port alu_out  input  64  ALU result.
REQ-012 SHALL have port z_out  output  64  captured result register, {hi, lo}.
REQ-013 SHALL have port done  output  1  one-cycle pulse, z_out/err valid.
REQ-014 SHALL have port err  output  1  sticky until next accept; illegal opcode or DIV by zero.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, DONE.
REQ-016 IDLE: on accept SHALL latch opcode, a_in, b_in into op reg/op_a/op_b, clear err, load counter with L, go EXEC.
REQ-017 L SHALL be MUL_LAT for MUL, DIV_LAT for DIV, 1 for all other legal opcodes.
REQ-018 EXEC: alu_ctl SHALL be one-hot of latched opcode every EXEC cycle; counter decrements each cycle.
REQ-019 On the EXEC cycle where counter == 1, z_out SHALL load alu_out at that edge; state goes DONE.
REQ-020 DONE: done SHALL be 1 for exactly one cycle; next state IDLE.
REQ-021 Latency: accept at edge T, done high in cycle T+L+1, ready again in cycle T+L+2.
REQ-022 alu_ctl SHALL be all-zero in IDLE and DONE; never more than one bit set.
REQ-023 op_a/op_b SHALL stay constant from accept until next accept.
REQ-024 Illegal opcode on accept: SHALL go directly to DONE, err=1, z_out unchanged, alu_ctl never asserted.
REQ-025 DIV with b_in == 0 on accept: same as REQ-024 (direct to DONE, err=1, z_out unchanged).
REQ-026 start while not ready (EXEC or DONE) SHALL be ignored with no side effect; no queuing.
REQ-027 Counter width SHALL hold max(MUL_LAT, DIV_LAT); no wrap possible.

Reset
REQ-028 clear SHALL, at the next edge, force IDLE, z_out=0, op_a=op_b=0, counter=0, err=0, done=0, alu_ctl=0, regardless of state.
REQ-029 clear mid-EXEC SHALL abort the operation with no z_out update and no done pulse.
REQ-030 clear has priority over start in the same cycle; ready is 1 the cycle after clear.

Structure
REQ-031 Opcode encodings, opcode width, one-hot ctl width and state encodings SHALL live in a shared package/include used by the decoder and this block.
REQ-032 One sub-module, alu_op_decode (opcode -> one-hot ctl, latency select, illegal flag), combinational; FSM, counter and registers stay in alu_sequencer.

Verification
REQ-033 ADD a=5, b=7 -> alu_ctl bit0 for 1 cycle, z_out=64'd12, done in cycle T+2, err=0.
REQ-034 MUL a=32'hFFFF_FFFF, b=2, MUL_LAT=4 -> bit2 held 4 cycles, z_out=64'h1_FFFF_FFFE, done at T+5.
REQ-035 DIV a=17, b=5 -> bit3 held DIV_LAT cycles, z_out={32'd2, 32'd3}; DIV b=0 -> done at T+1, err=1, z_out unchanged.
REQ-036 opcode 14 -> no alu_ctl bits ever, done at T+1, err=1; next legal op clears err.
REQ-037 start pulsed every cycle during a MUL -> only first accepted, op_a/op_b stable, single done.
REQ-038 clear asserted mid-DIV (EXEC cycle 10) -> next cycle IDLE, all outputs 0, no done; fresh ADD then completes normally.
